// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-ported data memory: port A has priority, and a
// bounded-wait counter forces a slot for port B. Read data returns one cycle after the grant.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_stall,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   typedef enum logic {A_PRI, B_FORCE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     wait_cnt, cnt_nxt;
   logic [1:0]        rd_acc;
   logic [1:0]        rvalid_q;
   logic [DATA_W-1:0] rdata_q [2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= A_PRI;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      case (state)
         A_PRI: begin
            a_gnt = a_req;
            b_gnt = b_req & ~a_req;
         end
         B_FORCE: begin
            // A may still use the slot if B withdrew its request.
            b_gnt     = b_req;
            a_gnt     = a_req & ~b_req;
            state_nxt = A_PRI;
         end
         default: state_nxt = A_PRI;
      endcase
      if (!b_req || b_gnt)    cnt_nxt = '0;
      else if (wait_cnt != LIM) cnt_nxt = wait_cnt + 1'b1;
      if (state == A_PRI && cnt_nxt == LIM) state_nxt = B_FORCE;
   end

   assign a_stall = a_req & ~a_gnt;
   assign mem_en  = a_gnt | b_gnt;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
      // Grants stay live during reset, so writes must be blocked explicitly.
      if (!reset_n) mem_we = 1'b0;
   end

   assign rd_acc = {b_gnt & ~b_we, a_gnt & ~a_we};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_q <= '0;
         for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
      end else begin
         rvalid_q <= rd_acc;
         for (int p = 0; p < 2; p++)
            if (rd_acc[p]) rdata_q[p] <= mem_rdata;
      end
   end

   assign a_rvalid = rvalid_q[0];
   assign b_rvalid = rvalid_q[1];
   assign a_rdata  = rdata_q[0];
   assign b_rdata  = rdata_q[1];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 32-word memory.
module tb_dmem_port_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_req, a_we, b_req, b_we;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        mem_en, mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] mem [32];
   logic [31:0] wr_mask = '0;

   always #5 clk = ~clk;

   // Unwritten words read as addr*100.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         wr_mask[mem_addr] <= 1'b1;
      end
   end
   assign mem_rdata = wr_mask[mem_addr] ? mem[mem_addr] : 32'(mem_addr) * 32'd100;

   dmem_port_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 32'd123;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0;   b_wdata = '0;

      // reset: A still granted, write strobe gated, registered outputs zero
      @(negedge clk);
      chk("rst_a_gnt", 32'(a_gnt), 1);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_a_rvalid", 32'(a_rvalid), 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rvalid", 32'(b_rvalid), 0);
      next_cyc();
      a_req = 1'b0; a_we = 1'b0; reset_n = 1'b1;
      @(negedge clk);
      chk("idle_mem_en", 32'(mem_en), 0);
      chk("idle_mem_addr", 32'(mem_addr), 0);

      // A-only read of word 3
      next_cyc();
      a_req = 1'b1; a_addr = 5'd3;
      @(negedge clk);
      chk("ard_gnt", 32'(a_gnt), 1);
      chk("ard_stall", 32'(a_stall), 0);
      chk("ard_mem_addr", 32'(mem_addr), 3);
      next_cyc();
      a_req = 1'b0;
      @(negedge clk);
      chk("ard_rvalid", 32'(a_rvalid), 1);
      chk("ard_rdata", a_rdata, 300);
      next_cyc();
      @(negedge clk);
      chk("ard_rvalid_pulse", 32'(a_rvalid), 0);
      chk("ard_rdata_hold", a_rdata, 300);

      // reset while a read response is in flight
      next_cyc();
      a_req = 1'b1; a_addr = 5'd3;
      next_cyc();
      reset_n = 1'b0; a_req = 1'b0;
      @(negedge clk);
      chk("rstf_a_rvalid", 32'(a_rvalid), 0);
      chk("rstf_a_rdata", a_rdata, 0);
      next_cyc();
      reset_n = 1'b1;

      // A reads word 5, then B write + read of word 7
      next_cyc();
      a_req = 1'b1; a_addr = 5'd5;
      next_cyc();
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("a_rdata_5", a_rdata, 500);
      chk("bwr_gnt", 32'(b_gnt), 1);
      chk("bwr_mem_we", 32'(mem_we), 1);
      chk("bwr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      next_cyc();
      b_we = 1'b0;
      @(negedge clk);
      chk("bwr_no_rvalid", 32'(b_rvalid), 0);
      chk("brd_gnt", 32'(b_gnt), 1);
      next_cyc();
      b_req = 1'b0;
      @(negedge clk);
      chk("brd_rvalid", 32'(b_rvalid), 1);
      chk("brd_rdata", b_rdata, 32'hDEADBEEF);
      chk("brd_a_rdata_kept", a_rdata, 500);
      chk("brd_a_rvalid", 32'(a_rvalid), 0);

      // contention: both request, pattern A,A,A,A,B
      next_cyc();
      a_req = 1'b1; a_addr = 5'd3; b_req = 1'b1; b_addr = 5'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("cont_b_gnt[%0d]", i), 32'(b_gnt), 32'(i % 5 == 4));
         chk($sformatf("cont_a_gnt[%0d]", i), 32'(a_gnt), 32'(i % 5 != 4));
         chk($sformatf("cont_a_stall[%0d]", i), 32'(a_stall), 32'(i % 5 == 4));
         chk($sformatf("cont_b_rvalid[%0d]", i), 32'(b_rvalid), 32'(i % 5 == 0 && i > 0));
         next_cyc();
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      chk("cont_b_rdata", b_rdata, 500);
      next_cyc();

      // B withdraws after 3 denied cycles: counter restarts
      for (int i = 0; i < 9; i++) begin
         a_req = 1'b1;
         b_req = (i != 3);
         @(negedge clk);
         chk($sformatf("drop_b_gnt[%0d]", i), 32'(b_gnt), 32'(i == 8));
         next_cyc();
      end
      a_req = 1'b0; b_req = 1'b0;
      next_cyc();

      // write at edge n by A is seen by B read granted in cycle n+1
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd2; a_wdata = 32'd55;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
      @(negedge clk);
      chk("ord_a_gnt", 32'(a_gnt), 1);
      chk("ord_b_denied", 32'(b_gnt), 0);
      next_cyc();
      a_req = 1'b0; a_we = 1'b0;
      @(negedge clk);
      chk("ord_b_gnt", 32'(b_gnt), 1);
      chk("ord_mem_addr", 32'(mem_addr), 2);
      next_cyc();
      b_req = 1'b0;
      @(negedge clk);
      chk("ord_b_rvalid", 32'(b_rvalid), 1);
      chk("ord_b_rdata", b_rdata, 55);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   always @(negedge clk) begin
      if (a_gnt && b_gnt) begin
         n_chk++;
         $display("FAIL both_gnt: a_gnt=1 b_gnt=1 expected at most one at %0t", $time);
      end
   end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter and sequencer for the single-ported 32 x 32-bit data memory. The arbiter shares the memory between the pipeline MEM stage (port A, priority) and a loader/debug master (port B). It grants at most one access per cycle and returns read data on a registered one-cycle response path. A bounded-wait counter guarantees port B forward progress, and the arbiter stalls the pipeline when port A loses a slot.

## Interface
- ADDR_W, 5, memory word-address width (32 words)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied cycles of port B before B is forced a slot; legal range 1..15
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A granted this cycle
- a_stall  out  1  a_req & ~a_gnt; freezes the pipeline
- a_rvalid  out  1  one-cycle pulse, a_rdata valid
- a_rdata  out  DATA_W  port A read data, held until the next port A read completes
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same definitions for port B (no stall output)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe (memory writes on rising edge)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data for mem_addr

## Operation
- Requester holds req/we/addr/wdata stable until it samples gnt=1. A transfer is accepted on the rising edge where req&gnt=1.
- State machine, 2 states:
  - A_PRI (reset state): if a_req, grant A; else if b_req, grant B.
  - B_FORCE: if b_req, grant B, deny A. Go to A_PRI after the B grant or if b_req=0.
  - A_PRI -> B_FORCE when wait_cnt reaches STARVE_LIMIT on a clock edge.
- wait_cnt: width $clog2(STARVE_LIMIT+1).
  - Increments on each edge with b_req & ~b_gnt.
  - Clears on a B grant or when b_req=0.
  - Saturates at STARVE_LIMIT and never wraps.
- Grant is combinational from req and state. At most one of a_gnt/b_gnt is high in any cycle.
- mem_en = a_gnt|b_gnt. mem_we/mem_addr/mem_wdata are muxed from the granted port; they are 0 when idle.
- Accepted read: on the same edge, mem_rdata is registered into that port's rdata and its rvalid is set for exactly one cycle.
- Accepted write: no rvalid. The other port's rdata is unchanged.
- The arbiter never issues simultaneous read and write. A write accepted at edge n is visible to any read granted after edge n.
- Asynchronous reset (any time, including with a read in flight):
  - state=A_PRI, wait_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Any pending response is discarded.
  - Combinational outputs follow the reset state: gnt is based on A_PRI, so a_req alone is granted even during reset. mem_we is gated to 0 while reset_n=0.

## Timing
- Grant latency: 0 cycles (same cycle as req when won).
- Read latency: rvalid/rdata 1 cycle after the accepting edge. Back-to-back reads on one port give an rvalid pulse every cycle.
- Worst-case B wait under continuous A traffic: STARVE_LIMIT denied cycles, then grant on the next cycle.
- Port A worst case: one stalled cycle per STARVE_LIMIT+1 cycles while B saturates.
- Outputs after reset: all gnt/stall/mem_* are combinational from inputs. Registered outputs are 0.

## Test plan
- Reset: assert reset_n=0 one cycle after an accepted A read of addr 3 -> a_rvalid stays 0, a_rdata=0, wait_cnt=0; release -> arbiter in A_PRI.
- A-only read: memory word 3=300, a_req/a_addr=3 -> a_gnt=1 same cycle, a_stall=0, next cycle a_rvalid=1, a_rdata=300.
- B write then read: b_we=1, addr 7, 0xDEADBEEF accepted; next cycle B read addr 7 -> b_rvalid=1 one cycle later, b_rdata=0xDEADBEEF. a_rdata unchanged.
- Contention, STARVE_LIMIT=4, both requesting continuously -> grant pattern A,A,A,A,B repeating. a_stall=1 only in the B cycles. No cycle has both gnts.
- B drops b_req after 3 denied cycles, re-asserts next cycle with A saturating -> wait_cnt restarts; B granted only after 4 further denied cycles.
- Write-read ordering: A writes 55 to addr 2 at edge n, B reads addr 2 granted in cycle n+1 -> b_rdata=55.
